// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the write-back port arbiter: default widths,
// the hardwired-zero register index and the two-way grant encoding.
package wb_port_arbiter_pkg;

  localparam int AWIDTH_DEF = 4;
  localparam int DWIDTH_DEF = 16;
  localparam int REG_ZERO   = 0;

  // Also used as the bit index of each requester in req/gnt vectors.
  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_port_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot (or zero) grant, remembers the last
// winner so a continuous contest alternates between the requesters.
module rr_arb2
  import wb_port_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  grant_e last_grant;

  // Nothing is granted while clear is high so held requests survive it untouched.
  always_comb begin
    gnt = 2'b00;
    if (!clear) begin
      if (req[GNT_ALU] && req[GNT_MEM]) begin
        if (last_grant == GNT_ALU) gnt[GNT_MEM] = 1'b1;
        else                       gnt[GNT_ALU] = 1'b1;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      last_grant <= GNT_MEM;
    end else if (gnt[GNT_ALU]) begin
      last_grant <= GNT_ALU;
    end else if (gnt[GNT_MEM]) begin
      last_grant <= GNT_MEM;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the ALU and load write-back paths and
// flags decode read hazards against any write that is pending or in flight.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              alu_valid,
  input  logic [AWIDTH-1:0] alu_addr,
  input  logic [DWIDTH-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [AWIDTH-1:0] mem_addr,
  input  logic [DWIDTH-1:0] mem_data,
  output logic              mem_ready,
  output logic              req_rd,
  output logic [AWIDTH-1:0] addr_rd,
  output logic [DWIDTH-1:0] wdata,
  input  logic [AWIDTH-1:0] chk_addr_rs,
  input  logic [AWIDTH-1:0] chk_addr_rt,
  input  logic              chk_en,
  output logic              stall
);

  localparam logic [AWIDTH-1:0] REG0 = AWIDTH'(REG_ZERO);

  logic [1:0] gnt;
  logic       rs_hit;
  logic       rt_hit;

  rr_arb2 u_arb (
    .clk   (clk),
    .clear (clear),
    .req   ({mem_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[GNT_ALU];
  assign mem_ready = gnt[GNT_MEM];

  // A grant to register zero is consumed but never reaches the regfile;
  // address and data keep their previous values in that case.
  always_ff @(posedge clk) begin
    if (clear) begin
      req_rd  <= 1'b0;
      addr_rd <= '0;
      wdata   <= '0;
    end else begin
      req_rd <= 1'b0;
      if (gnt[GNT_ALU] && alu_addr != REG0) begin
        req_rd  <= 1'b1;
        addr_rd <= alu_addr;
        wdata   <= alu_data;
      end else if (gnt[GNT_MEM] && mem_addr != REG0) begin
        req_rd  <= 1'b1;
        addr_rd <= mem_addr;
        wdata   <= mem_data;
      end
    end
  end

  always_comb begin
    rs_hit = (chk_addr_rs != REG0) &&
             ((alu_valid && alu_addr == chk_addr_rs) ||
              (mem_valid && mem_addr == chk_addr_rs) ||
              (req_rd    && addr_rd  == chk_addr_rs));
    rt_hit = (chk_addr_rt != REG0) &&
             ((alu_valid && alu_addr == chk_addr_rt) ||
              (mem_valid && mem_addr == chk_addr_rt) ||
              (req_rd    && addr_rd  == chk_addr_rt));
    stall  = chk_en && (rs_hit || rt_hit);
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single write port of the register file (regfile_v2: req_rd/addr_rd/wdata) between two write-back requesters: ALU result path and memory-load path.
- Round-robin arbitration with a valid/ready handshake; registered write outputs.
- Also exposes a read-hazard scoreboard so decode stalls when it would read a register whose write is still in flight.
- Sits between execute/memory stages and regfile_v2.

Parameters:
- AWIDTH, 4, register address width (2^AWIDTH registers).
- DWIDTH, 16, register data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clear  in  1  synchronous active-high reset.
- alu_valid  in  1  ALU write-back request.
- alu_addr  in  AWIDTH  ALU destination register.
- alu_data  in  DWIDTH  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mem_valid  in  1  load write-back request.
- mem_addr  in  AWIDTH  load destination register.
- mem_data  in  DWIDTH  load data.
- mem_ready  out  1  load request accepted this cycle (combinational).
- req_rd  out  1  regfile write strobe (registered).
- addr_rd  out  AWIDTH  regfile write address (registered).
- wdata  out  DWIDTH  regfile write data (registered).
- chk_addr_rs  in  AWIDTH  decode rs address to check.
- chk_addr_rt  in  AWIDTH  decode rt address to check.
- chk_en  in  1  decode check enable.
- stall  out  1  read hazard pending (combinational).

Behaviour:
- Reset (clear=1 at edge): req_rd=0, addr_rd=0, wdata=0, last_grant=MEM (ALU wins the first contest). alu_ready=mem_ready=0 while clear is high. Any in-flight output write is dropped.
- Handshake: a requester holds valid, addr and data stable until it sees ready=1. Transfer occurs on an edge where valid&ready. At most one grant per cycle. Ready is never 1 without valid.
- Arbitration (grant state = last_grant, values ALU/MEM):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - last_grant updates to the granted requester on every grant; it is unchanged when there is no grant.
- Output: on a grant, next cycle req_rd=1, addr_rd=granted addr, wdata=granted data. Latency is exactly 1 cycle. With no grant, req_rd=0 next cycle; addr_rd/wdata hold their last value.
- Register zero: a grant with addr==0 still asserts ready (request consumed) and updates last_grant, but req_rd stays 0 next cycle.
- Throughput: one write per cycle sustained. Back-to-back grants produce back-to-back req_rd pulses.
- Hazard: stall=1 iff chk_en=1 and (chk_addr_rs!=0 or chk_addr_rt!=0) and that nonzero address matches any of:
  - alu_addr with alu_valid;
  - mem_addr with mem_valid;
  - addr_rd with req_rd.
  Decode must not read on the cycle the same address is being written. Address 0 never stalls.
- Both requesters targeting the same address: both writes are issued in grant order. The later grant's data is the final regfile value.
- clear mid-contest: last_grant returns to MEM. Pending requests stay pending (held by requesters) and are arbitrated normally after clear drops.

Decomposition:
- Shared package: AWIDTH/DWIDTH defaults, REG_ZERO constant (0), grant encoding (GNT_ALU=0, GNT_MEM=1).
- One sub-module: rr_arb2, a 2-input round-robin arbiter holding last_grant (inputs clk, clear, req[1:0]; output gnt[1:0] one-hot or zero).
- Output register, zero-drop and hazard comparators live in wb_port_arbiter.

Test Plan:
- Reset then idle: clear high 5 cycles -> req_rd=0, addr_rd=0, wdata=0, both ready=0; after clear low with no valid -> req_rd stays 0.
- Single ALU write: alu_valid=1, addr=1, data=0x0001 for one accepted cycle -> alu_ready=1 same cycle; next cycle req_rd=1, addr_rd=1, wdata=0x0001; following cycle req_rd=0.
- Contention: both valid continuously (ALU addr=2 data=2, MEM addr=3 data=8, each requester drops valid after its accept) -> ALU granted first, MEM second; req_rd pulses on 2 consecutive cycles, addr_rd 2 then 3.
- Zero drop: mem_valid with mem_addr=0, data=0xFFFF -> mem_ready=1, req_rd stays 0; next contention grants ALU first.
- Hazard: mem_valid with addr=2 held (ALU also contending and winning), chk_en=1, chk_addr_rs=2 -> stall=1 until the cycle after req_rd for addr 2; chk_addr_rs=0 -> stall=0.
- Reset mid-operation: grant ALU, assert clear the next cycle -> req_rd=0 after that edge (write dropped); after clear drops with both valid -> ALU granted first.
